// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: frame-synchronous 4-digit seven-segment scan driver.
// Optional SEG7_LZB_EN enables leading-zero blanking.
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV = 270000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digit_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        blank,
    output logic [3:0]  led,
    output logic [7:0]  display,
    output logic        frame_done
);

    localparam logic [29:0] LAST = 30'(SCAN_DIV - 1);

    logic [29:0] cnt_q, cnt_d;
    logic [1:0]  pos_q, pos_d;
    logic [15:0] pend_q, pend_d;
    logic [3:0]  pend_dp_q, pend_dp_d;
    logic        pend_v_q, pend_v_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  shadow_dp_q, shadow_dp_d;
    logic [3:0]  led_q, led_d;
    logic [7:0]  display_q, display_d;
    logic        frame_done_q, frame_done_d;

    logic        tick;
    logic        boundary;
    logic [3:0]  cur_digit;
    logic        cur_dot;
    logic [3:0]  lead_zero;

    function automatic logic [6:0] seg7(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = 7'b0001000;
            4'd1:    s = 7'b1101101;
            4'd2:    s = 7'b0100010;
            4'd3:    s = 7'b0100100;
            4'd4:    s = 7'b1000101;
            4'd5:    s = 7'b0010100;
            4'd6:    s = 7'b0010000;
            4'd7:    s = 7'b0001101;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Next-state: prescaler, scan position, frame buffering and output decode
    always_comb begin
        tick         = (cnt_q == LAST);
        boundary     = tick && (pos_q == 2'd0);
        cnt_d        = tick ? 30'd0 : cnt_q + 30'd1;
        pos_d        = tick ? pos_q - 2'd1 : pos_q;
        pend_d       = pend_q;
        pend_dp_d    = pend_dp_q;
        pend_v_d     = pend_v_q;
        shadow_d     = shadow_q;
        shadow_dp_d  = shadow_dp_q;
        led_d        = led_q;
        display_d    = display_q;
        frame_done_d = boundary;

        if (load) begin
            pend_d    = digit_in;
            pend_dp_d = dp_in;
            pend_v_d  = 1'b1;
        end

        // Swap only at the boundary so a frame is never torn; a load in
        // the boundary cycle bypasses the pending slot.
        if (boundary) begin
            if (load) begin
                shadow_d    = digit_in;
                shadow_dp_d = dp_in;
            end else if (pend_v_q) begin
                shadow_d    = pend_q;
                shadow_dp_d = pend_dp_q;
            end
            pend_v_d = 1'b0;
        end

        cur_digit = shadow_d[{pos_d, 2'b00} +: 4];
        cur_dot   = shadow_dp_d[pos_d];

`ifdef SEG7_LZB_EN
        lead_zero[3] = (shadow_d[15:12] == 4'd0) && !shadow_dp_d[3];
        lead_zero[2] = lead_zero[3] && (shadow_d[11:8] == 4'd0)
                       && !shadow_dp_d[2];
        lead_zero[1] = lead_zero[2] && (shadow_d[7:4] == 4'd0)
                       && !shadow_dp_d[1];
        lead_zero[0] = 1'b0;
`else
        lead_zero = 4'b0000;
`endif

        if (tick) begin
            if (blank) begin
                led_d     = 4'b1111;
                display_d = 8'hFF;
            end else begin
                led_d = ~(4'b0001 << pos_d);
                if (lead_zero[pos_d]) begin
                    display_d = 8'hFF;
                end else begin
                    display_d = {seg7(cur_digit), ~cur_dot};
                end
            end
        end
    end

    // State and registered outputs; reset darkens the display at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= 30'd0;
            pos_q        <= 2'd0;
            pend_q       <= 16'd0;
            pend_dp_q    <= 4'd0;
            pend_v_q     <= 1'b0;
            shadow_q     <= 16'd0;
            shadow_dp_q  <= 4'd0;
            led_q        <= 4'b1111;
            display_q    <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            pos_q        <= pos_d;
            pend_q       <= pend_d;
            pend_dp_q    <= pend_dp_d;
            pend_v_q     <= pend_v_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            led_q        <= led_d;
            display_q    <= display_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign led        = led_q;
    assign display    = display_q;
    assign frame_done = frame_done_q;

endmodule
